// File: rtl/sensor_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter between 8 sensor controllers.
// Optional byte timeout is compiled in when SENSOR_TX_TIMEOUT_EN is defined.
module sensor_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   sensor_ready,
  input  logic [127:0] sensor_bus,
  input  logic         tx_done,
  output logic [7:0]   data_used,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  output logic [2:0]   grant_id,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HI,
    S_WAIT_HI,
    S_SEND_LO,
    S_WAIT_LO
  } state_e;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= (1 << 17)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in [2, 2^17)");
  end

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [15:0] word_q, word_d;
  logic [2:0]  grant_q, grant_d;
  logic [7:0]  data_used_q, data_used_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        in_wait;
  logic        timeout_hit;

  // Cyclic priority scan: walk offsets high to low so the smallest offset from ptr wins.
  logic [2:0]  pick;
  logic        pick_vld;

  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (sensor_ready[ptr_q + 3'(i)]) begin
        pick     = ptr_q + 3'(i);
        pick_vld = 1'b1;
      end
    end
  end

  assign in_wait = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);

`ifdef SENSOR_TX_TIMEOUT_EN
  logic [16:0] cnt_q, cnt_d;
  logic        cnt_last;
  logic        timeout_err_q;

  assign cnt_last    = (cnt_q == 17'(TIMEOUT_CYCLES - 1));
  // tx_done on the terminal-count cycle takes priority over the abort.
  assign timeout_hit = in_wait && !tx_done && cnt_last;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SEND_HI || state_q == S_SEND_LO) begin
      cnt_d = '0;
    end else if (in_wait && !tx_done && !cnt_last) begin
      cnt_d = cnt_q + 17'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_hit;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    word_d      = word_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    data_used_d = 8'h00;
    tx_start_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          word_d      = sensor_bus[{pick, 4'b0000} +: 16];
          grant_d     = pick;
          data_used_d = 8'h01 << pick;
          state_d     = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        tx_data_d  = word_q[15:8];
        tx_start_d = 1'b1;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_done) begin
          state_d = S_SEND_LO;
        end else if (timeout_hit) begin
          word_d  = '0;
          ptr_d   = grant_q + 3'd1;
          state_d = S_IDLE;
        end
      end
      S_SEND_LO: begin
        tx_data_d  = word_q[7:0];
        tx_start_d = 1'b1;
        state_d    = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (tx_done) begin
          ptr_d   = grant_q + 3'd1;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          word_d  = '0;
          ptr_d   = grant_q + 3'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd0;
      word_q      <= 16'h0000;
      grant_q     <= 3'd0;
      data_used_q <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      word_q      <= word_d;
      grant_q     <= grant_d;
      data_used_q <= data_used_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
    end
  end

  assign data_used = data_used_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sensor_tx_scheduler.sv
// Directed self-checking bench for sensor_tx_scheduler with an auto-responding UART model.
module tb_sensor_tx_scheduler;

  localparam int TO_CYCLES  = 20;
  localparam int DONE_DELAY = 10;
  localparam int MAX_CYC    = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   sensor_ready;
  logic [127:0] sensor_bus;
  logic         tx_done;
  logic [7:0]   data_used;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic [2:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  logic auto_done = 1'b1;

  int checks   = 0;
  int failures = 0;
  int terr_cnt = 0;

  logic [10:0] start_q[$];
  logic [7:0]  used_q[$];

  assign tx_done = resp_done | spur_done;

  sensor_tx_scheduler #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_ready (sensor_ready),
    .sensor_bus   (sensor_bus),
    .tx_done      (tx_done),
    .data_used    (data_used),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // UART model: tx_done pulses for one cycle, DONE_DELAY cycles after tx_start.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      resp_done = 1'b0;
      if (tx_start && auto_done) begin
        repeat (DONE_DELAY - 1) @(posedge clk);
        #1;
        resp_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (tx_start) start_q.push_back({grant_id, tx_data});
    if (data_used != 8'h00) used_q.push_back(data_used);
    if (timeout_err) terr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    start_q.delete();
    used_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sensor_ready = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic run_words(input logic [7:0] mask, input int n_words, input bit keep);
    int cyc;
    cyc = 0;
    sensor_ready = mask;
    while ((used_q.size() < n_words || busy) && cyc < MAX_CYC) begin
      tick();
      cyc++;
      if (data_used != 8'h00) begin
        if (!keep) sensor_ready = sensor_ready & ~data_used;
        else if (used_q.size() >= n_words) sensor_ready = 8'h00;
      end
    end
    sensor_ready = 8'h00;
    checks++;
    if (cyc >= MAX_CYC) begin
      $display("FAIL run_words_timeout: got %0d grants, required %0d", used_q.size(), n_words);
      failures++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sensor_ready = 8'h00;
    sensor_bus = '0;
    repeat (3) tick();
    checks++; if (data_used !== 8'h00) begin $display("FAIL reset_data_used: got %h required 00", data_used); failures++; end
    checks++; if (tx_data !== 8'h00) begin $display("FAIL reset_tx_data: got %h required 00", tx_data); failures++; end
    checks++; if (tx_start !== 1'b0) begin $display("FAIL reset_tx_start: got %b required 0", tx_start); failures++; end
    checks++; if (grant_id !== 3'd0) begin $display("FAIL reset_grant_id: got %0d required 0", grant_id); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b required 0", busy); failures++; end
    checks++; if (timeout_err !== 1'b0) begin $display("FAIL reset_timeout_err: got %b required 0", timeout_err); failures++; end
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  // Shared tail: from the cycle after the high-byte tx_start, expect the low byte
  // 11 cycles later and IDLE 10 cycles after that.
  task automatic expect_low_byte(input string tag, input logic [7:0] lo, input logic [2:0] g);
    int n;
    n = 1;
    tick();
    while (!tx_start && n < 100) begin tick(); n++; end
    checks++; if (n !== 11) begin $display("FAIL %s_lo_latency: got %0d required 11", tag, n); failures++; end
    checks++; if (tx_data !== lo) begin $display("FAIL %s_lo_byte: got %h required %h", tag, tx_data, lo); failures++; end
    checks++; if (grant_id !== g) begin $display("FAIL %s_grant_id: got %0d required %0d", tag, grant_id, g); failures++; end
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    checks++; if (n !== 10) begin $display("FAIL %s_idle_latency: got %0d required 10", tag, n); failures++; end
    checks++; if (tx_data !== lo) begin $display("FAIL %s_tx_data_hold: got %h required %h", tag, tx_data, lo); failures++; end
  endtask

  task automatic test_single_sensor();
    do_reset();
    sensor_bus = '0;
    sensor_bus[16*3 +: 16] = 16'hA5C3;
    sensor_ready = 8'h08;
    tick();
    checks++; if (data_used !== 8'h08) begin $display("FAIL single_ack: got %h required 08", data_used); failures++; end
    checks++; if (grant_id !== 3'd3) begin $display("FAIL single_grant: got %0d required 3", grant_id); failures++; end
    checks++; if (busy !== 1'b1) begin $display("FAIL single_busy: got %b required 1", busy); failures++; end
    sensor_ready = 8'h00;
    tick();
    checks++; if (data_used !== 8'h00) begin $display("FAIL single_ack_width: got %h required 00", data_used); failures++; end
    checks++; if (tx_start !== 1'b1) begin $display("FAIL single_hi_start: got %b required 1", tx_start); failures++; end
    checks++; if (tx_data !== 8'hA5) begin $display("FAIL single_hi_byte: got %h required a5", tx_data); failures++; end
    expect_low_byte("single", 8'hC3, 3'd3);
  endtask

  task automatic test_spurious_done();
    do_reset();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin $display("FAIL spur_idle: got busy=%b start=%b required 0 0", busy, tx_start); failures++; end
    sensor_bus = '0;
    sensor_bus[16*2 +: 16] = 16'h3C96;
    sensor_ready = 8'h04;
    tick();
    checks++; if (data_used !== 8'h04) begin $display("FAIL spur_ack: got %h required 04", data_used); failures++; end
    sensor_ready = 8'h00;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin $display("FAIL spur_hi: got start=%b data=%h required 1 3c", tx_start, tx_data); failures++; end
    expect_low_byte("spur", 8'h96, 3'd2);
  endtask

  task automatic test_all_ready();
    logic [15:0] w;
    logic [2:0]  g;
    do_reset();
    for (int i = 0; i < 8; i++) sensor_bus[16*i +: 16] = 16'(32'h1110 * (i + 1));
    run_words(8'hFF, 9, 1'b1);
    checks++; if (used_q.size() !== 9) begin $display("FAIL all_grant_count: got %0d required 9", used_q.size()); failures++; end
    checks++; if (start_q.size() !== 18) begin $display("FAIL all_start_count: got %0d required 18", start_q.size()); failures++; end
    for (int k = 0; k < 9; k++) begin
      g = 3'(k % 8);
      w = 16'(32'h1110 * ((k % 8) + 1));
      if (used_q.size() > k) begin
        checks++; if (used_q[k] !== (8'h01 << g)) begin $display("FAIL all_grant_%0d: got %h required %h", k, used_q[k], 8'h01 << g); failures++; end
      end
      if (start_q.size() > 2 * k + 1) begin
        checks++; if (start_q[2*k] !== {g, w[15:8]}) begin $display("FAIL all_hi_%0d: got %h required %h", k, start_q[2*k], {g, w[15:8]}); failures++; end
        checks++; if (start_q[2*k+1] !== {g, w[7:0]}) begin $display("FAIL all_lo_%0d: got %h required %h", k, start_q[2*k+1], {g, w[7:0]}); failures++; end
      end
    end
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    sensor_bus = '0;
    sensor_bus[16*5 +: 16] = 16'h5555;
    run_words(8'h20, 1, 1'b0);
    clear_logs();
    sensor_bus[16*7 +: 16] = 16'h7E01;
    sensor_bus[16*1 +: 16] = 16'h1E02;
    run_words(8'h82, 2, 1'b0);
    checks++; if (used_q.size() !== 2) begin $display("FAIL wrap_count: got %0d required 2", used_q.size()); failures++; end
    else begin
      checks++; if (used_q[0] !== 8'h80 || used_q[1] !== 8'h02) begin $display("FAIL wrap_order: got %h %h required 80 02", used_q[0], used_q[1]); failures++; end
    end
    checks++; if (start_q.size() !== 4) begin $display("FAIL wrap_starts: got %0d required 4", start_q.size()); failures++; end
    else begin
      checks++; if (start_q[0] !== {3'd7, 8'h7E} || start_q[1] !== {3'd7, 8'h01} || start_q[2] !== {3'd1, 8'h1E} || start_q[3] !== {3'd1, 8'h02})
        begin $display("FAIL wrap_bytes: got %h %h %h %h required 77e 701 11e 102", start_q[0], start_q[1], start_q[2], start_q[3]); failures++; end
    end
    clear_logs();
    sensor_bus[16*0 +: 16] = 16'h0A0B;
    run_words(8'h81, 2, 1'b0);
    checks++; if (used_q.size() !== 2) begin $display("FAIL wrap_ptr2_count: got %0d required 2", used_q.size()); failures++; end
    else begin
      checks++; if (used_q[0] !== 8'h80 || used_q[1] !== 8'h01) begin $display("FAIL wrap_ptr2_order: got %h %h required 80 01", used_q[0], used_q[1]); failures++; end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int quiet;
    do_reset();
    sensor_bus = '0;
    sensor_bus[16*4 +: 16] = 16'h4444;
    run_words(8'h10, 1, 1'b0);
    clear_logs();
    sensor_bus[16*6 +: 16] = 16'h6A6B;
    sensor_bus[16*2 +: 16] = 16'h2A2B;
    sensor_ready = 8'h44;
    n = 0;
    while (data_used == 8'h00 && n < 50) begin tick(); n++; end
    checks++; if (data_used !== 8'h40) begin $display("FAIL mid_first_grant: got %h required 40", data_used); failures++; end
    sensor_ready = 8'h04;
    n = 0;
    while (!(tx_start && tx_data == 8'h6B) && n < 100) begin tick(); n++; end
    checks++; if (n >= 100) begin $display("FAIL mid_lo_start_seen: got timeout required low-byte start"); failures++; end
    rst = 1'b1;
    sensor_ready = 8'h00;
    tick();
    rst = 1'b0;
    checks++; if ({data_used, tx_data, tx_start, grant_id, busy, timeout_err} !== 22'h0)
      begin $display("FAIL mid_reset_outputs: got used=%h data=%h start=%b gid=%0d busy=%b terr=%b required all 0", data_used, tx_data, tx_start, grant_id, busy, timeout_err); failures++; end
    quiet = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tx_start || data_used != 8'h00 || busy) quiet++;
    end
    checks++; if (quiet !== 0) begin $display("FAIL mid_quiet: got %0d active cycles required 0", quiet); failures++; end
    clear_logs();
    run_words(8'h44, 2, 1'b0);
    checks++; if (used_q.size() !== 2) begin $display("FAIL mid_regrant_count: got %0d required 2", used_q.size()); failures++; end
    else begin
      checks++; if (used_q[0] !== 8'h04 || used_q[1] !== 8'h40) begin $display("FAIL mid_regrant_order: got %h %h required 04 40", used_q[0], used_q[1]); failures++; end
    end
  endtask

  task automatic test_timeout();
`ifdef SENSOR_TX_TIMEOUT_EN
    int n;
    do_reset();
    auto_done = 1'b0;
    sensor_bus = '0;
    sensor_bus[16*1 +: 16] = 16'h1234;
    sensor_bus[16*5 +: 16] = 16'h5678;
    sensor_ready = 8'h02;
    tick();
    checks++; if (data_used !== 8'h02) begin $display("FAIL to_ack: got %h required 02", data_used); failures++; end
    sensor_ready = 8'h00;
    tick();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h12) begin $display("FAIL to_hi: got start=%b data=%h required 1 12", tx_start, tx_data); failures++; end
    n = 0;
    while (!timeout_err && n < 100) begin tick(); n++; end
    checks++; if (n !== TO_CYCLES) begin $display("FAIL to_latency: got %0d required %0d", n, TO_CYCLES); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL to_idle: got %b required 0", busy); failures++; end
    checks++; if (start_q.size() !== 1) begin $display("FAIL to_no_lo: got %0d starts required 1", start_q.size()); failures++; end
    tick();
    checks++; if (timeout_err !== 1'b0) begin $display("FAIL to_pulse_width: got %b required 0", timeout_err); failures++; end
    auto_done = 1'b1;
    clear_logs();
    run_words(8'h22, 2, 1'b0);
    checks++; if (used_q.size() !== 2) begin $display("FAIL to_next_count: got %0d required 2", used_q.size()); failures++; end
    else begin
      checks++; if (used_q[0] !== 8'h20 || used_q[1] !== 8'h02) begin $display("FAIL to_next_order: got %h %h required 20 02", used_q[0], used_q[1]); failures++; end
    end
`else
    checks++; if (terr_cnt !== 0) begin $display("FAIL no_timeout_err: got %0d pulses required 0", terr_cnt); failures++; end
`endif
  endtask

  initial begin
    rst = 1'b1;
    sensor_ready = 8'h00;
    sensor_bus = '0;
    test_reset();
    test_single_sensor();
    test_spurious_done();
    test_all_ready();
    test_ptr_wrap();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
